// File: rtl/pc_next_unit.sv
// Program-counter unit: holds the fetch PC and picks the next address from
// sequential increment, branch, jump and register-jump, with stall-safe redirect holding.
module pc_next_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] bta,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             redirect_pending,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] hold_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] sel_target;
  logic             req;

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] hold_next;
  logic             pending_next;
  logic             misaligned_next;
  logic [WIDTH-1:0] apply_target;

  assign pc_seq      = pc + INC_W;
  assign jump_target = {pc_seq[WIDTH-1:28], jump_index, 2'b00};
  assign req         = jr | jump | branch_taken;

  // Later assignments win: jr > jump > branch.
  always_comb begin
    sel_target = bta;
    if (jump) sel_target = jump_target;
    if (jr)   sel_target = jr_addr;
  end

  // Next-state selection; a live request displaces any held target.
  always_comb begin
    pc_next         = pc;
    hold_next       = hold_target;
    pending_next    = redirect_pending;
    misaligned_next = 1'b0;
    apply_target    = req ? sel_target : hold_target;

    if (stall) begin
      if (req) begin
        hold_next    = sel_target;
        pending_next = 1'b1;
      end
    end else if (req || redirect_pending) begin
      pc_next         = {apply_target[WIDTH-1:2], 2'b00};
      pending_next    = 1'b0;
      misaligned_next = |apply_target[1:0];
    end else begin
      pc_next = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_VECTOR;
      hold_target      <= '0;
      redirect_pending <= 1'b0;
      misaligned       <= 1'b0;
    end else begin
      pc               <= pc_next;
      hold_target      <= hold_next;
      redirect_pending <= pending_next;
      misaligned       <= misaligned_next;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the PC rules.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr;
  logic [31:0] bta, jr_addr;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_seq;
  logic        redirect_pending, misaligned;

  logic        w_reset;
  logic [31:0] w_pc, w_seq;
  logic        w_pend, w_mis;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  logic [31:0] m_pc, m_hold;
  logic        m_pend, m_mis;

  always #5 clk = ~clk;

  pc_next_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .bta(bta), .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
    .pc(pc), .pc_seq(pc_seq), .redirect_pending(redirect_pending),
    .misaligned(misaligned)
  );

  pc_next_unit #(.WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF8), .INC(4)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0), .branch_taken(1'b0),
    .bta(32'h0), .jump(1'b0), .jump_index(26'h0), .jr(1'b0), .jr_addr(32'h0),
    .pc(w_pc), .pc_seq(w_seq), .redirect_pending(w_pend), .misaligned(w_mis)
  );

  // Apply the PC rules to the inputs currently driven.
  task automatic model_update();
    logic        r;
    logic [31:0] tgt, seq;
    seq = m_pc + 32'd4;
    r   = jr | jump | branch_taken;
    if (jr)        tgt = jr_addr;
    else if (jump) tgt = {seq[31:28], jump_index, 2'b00};
    else           tgt = bta;
    if (reset) begin
      m_pc = 32'h0; m_hold = 32'h0; m_pend = 1'b0; m_mis = 1'b0;
    end else if (stall) begin
      m_mis = 1'b0;
      if (r) begin m_hold = tgt; m_pend = 1'b1; end
    end else if (r) begin
      m_pc = tgt & ~32'd3; m_mis = (tgt % 4) != 0; m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_hold & ~32'd3; m_mis = (m_hold % 4) != 0; m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4; m_mis = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branch_taken = 0; jump = 0; jr = 0;
    bta = 0; jr_addr = 0; jump_index = 0;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; tick(); reset = 0;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pc_seq !== 32'h4) begin failures++; $display("FAIL reset_pc_seq got=%h exp=%h", pc_seq, 32'h4); end
    checks++; if (redirect_pending !== 1'b0 || misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b exp=00", redirect_pending, misaligned); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      idle_inputs(); tick();
      checks++; if (pc !== 32'(4 * i) || pc_seq !== 32'(4 * i + 4)) begin
        failures++; $display("FAIL seq_step%0d got=%h/%h exp=%h/%h", i, pc, pc_seq, 4 * i, 4 * i + 4); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    w_reset = 1; @(posedge clk); #1; w_reset = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (w_pc !== exp_pc[i] || w_seq !== exp_pc[i] + 32'd4 || w_mis !== 1'b0) begin
        failures++; $display("FAIL wrap_step%0d got=%h exp=%h", i, w_pc, exp_pc[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic goto(input logic [31:0] a);
    idle_inputs(); branch_taken = 1; bta = a; tick(); idle_inputs();
  endtask

  task automatic test_priority();
    goto(32'h100);
    jr = 1; jump = 1; branch_taken = 1; jr_addr = 32'h400; jump_index = 26'h40; bta = 32'h200;
    tick();
    checks++; if (pc !== 32'h400) begin failures++; $display("FAIL prio_jr got=%h exp=%h", pc, 32'h400); end
    goto(32'h100);
    jump = 1; branch_taken = 1; jump_index = 26'h40; bta = 32'h200; jr_addr = 32'h400;
    tick();
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL prio_jump got=%h exp=%h", pc, 32'h100); end
    idle_inputs(); branch_taken = 1; bta = 32'h200; jump_index = 26'h40; jr_addr = 32'h400;
    tick();
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL prio_branch got=%h exp=%h", pc, 32'h200); end
  endtask

  task automatic test_stalled_redirect();
    logic [31:0] frozen;
    idle_inputs(); frozen = pc;
    stall = 1; branch_taken = 1; bta = 32'h300; tick();
    for (int i = 2; i <= 3; i++) begin
      checks++; if (pc !== frozen || redirect_pending !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%b exp=%h/1", i, pc, redirect_pending, frozen); end
      idle_inputs(); stall = 1; tick();
    end
    idle_inputs(); tick();
    checks++; if (pc !== 32'h300 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL stall_release got=%h/%b exp=300/0", pc, redirect_pending); end
  endtask

  task automatic test_latest_wins();
    idle_inputs(); stall = 1; branch_taken = 1; bta = 32'h300; tick();
    idle_inputs(); stall = 1; jr = 1; jr_addr = 32'h500; tick();
    idle_inputs(); tick();
    checks++; if (pc !== 32'h500 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL latest_wins got=%h/%b exp=500/0", pc, redirect_pending); end
    idle_inputs(); stall = 1; branch_taken = 1; bta = 32'h300; tick();
    idle_inputs(); stall = 1; jr = 1; jr_addr = 32'h500; tick();
    idle_inputs(); jump = 1; jump_index = 26'h200; tick();
    checks++; if (pc !== 32'h800 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL live_override got=%h/%b exp=800/0", pc, redirect_pending); end
    idle_inputs(); tick();
    checks++; if (pc !== 32'h804) begin failures++; $display("FAIL held_discarded got=%h exp=%h", pc, 32'h804); end
  endtask

  task automatic test_misaligned();
    idle_inputs(); jr = 1; jr_addr = 32'h1006; tick();
    checks++; if (pc !== 32'h1004 || misaligned !== 1'b1) begin
      failures++; $display("FAIL misalign_hit got=%h/%b exp=1004/1", pc, misaligned); end
    idle_inputs(); tick();
    checks++; if (pc !== 32'h1008 || misaligned !== 1'b0) begin
      failures++; $display("FAIL misalign_clear got=%h/%b exp=1008/0", pc, misaligned); end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs(); stall = 1; jr = 1; jr_addr = 32'h303; tick();
    idle_inputs(); reset = 1; stall = 1; tick();
    checks++; if (pc !== 32'h0 || redirect_pending !== 1'b0 || misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_mid_stall got=%h/%b/%b exp=0/0/0", pc, redirect_pending, misaligned); end
    idle_inputs(); tick();
    checks++; if (pc !== 32'h4 || misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_release got=%h/%b exp=4/0", pc, misaligned); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      reset        = ($urandom_range(0, 39) == 0);
      stall        = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 5) == 0);
      jr           = ($urandom_range(0, 6) == 0);
      bta          = $urandom;
      jr_addr      = $urandom;
      jump_index   = 26'($urandom);
      tick();
      checks++;
      if (pc !== m_pc || pc_seq !== m_pc + 32'd4 || redirect_pending !== m_pend || misaligned !== m_mis) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", n, pc, pc_seq,
                 redirect_pending, misaligned, m_pc, m_pc + 32'd4, m_pend, m_mis);
      end
    end
  endtask

  initial begin
    m_pc = 0; m_hold = 0; m_pend = 0; m_mis = 0;
    w_reset = 1;
    idle_inputs();
    #1;
    test_reset();
    test_sequential();
    test_wrap();
    test_priority();
    test_stalled_redirect();
    test_latest_wins();
    test_misaligned();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter unit for the pipelined CPU. It holds the PC register and computes the next fetch address from sequential increment, branch target, jump (J/JAL) and register-jump (JR) requests. It replaces the fixed three-stage 32-bit jump/branch mux cascade in the IF stage. Beyond that cascade it adds:

- a stall input;
- a pending-redirect holding register, so a redirect that arrives during a stall is not lost;
- alignment checking of redirect targets.

## Interface

Parameters:
- WIDTH, default 32: PC/address width. Must be ≥ 32.
- RESET_VECTOR, default 0: PC value after reset. Must be a multiple of 4.
- INC, default 4: sequential increment.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC (hazard unit load-use stall).
- branch_taken  input  1  branch decision AND-gate output.
- bta  input  WIDTH  branch target address.
- jump  input  1  J/JAL from control unit.
- jump_index  input  26  instruction bits 25:0.
- jr  input  1  JRControl from ALU control.
- jr_addr  input  WIDTH  rs register value.
- pc  output  WIDTH  current fetch address (registered).
- pc_seq  output  WIDTH  pc + INC (combinational, feeds JAL writeback).
- redirect_pending  output  1  a held redirect is awaiting the end of a stall (registered).
- misaligned  output  1  one-cycle flag: the last applied redirect target had bits [1:0] ≠ 0 (registered).

Reset: one clock (clk); reset is synchronous and active-high.

## Operation

**Redirect selection.** Priority, highest first: jr > jump > branch_taken > sequential. This matches the cascade order, in which JR overrides jump and jump overrides branch.
- Jump target = {pc_seq[WIDTH-1:28], jump_index, 2'b00}.
- JR target = jr_addr.
- Branch target = bta.
- req = jr | jump | branch_taken. sel_target = target of the highest-priority asserted request.

**Holding register.** Contents: hold_target (WIDTH bits) and redirect_pending.

**Next state, evaluated on every rising clk edge.**
- reset=1: pc ← RESET_VECTOR; hold_target ← 0; redirect_pending ← 0; misaligned ← 0. Reset overrides stall and any request.
- stall=1, req=1: pc unchanged; hold_target ← sel_target; redirect_pending ← 1. Latest request wins and overwrites an earlier held target.
- stall=1, req=0: pc, hold_target and redirect_pending unchanged.
- stall=0, req=1: pc ← sel_target with bits [1:0] forced to 0; redirect_pending ← 0. A live request beats a held one, and the held target is discarded.
- stall=0, req=0, redirect_pending=1: pc ← hold_target with bits [1:0] forced to 0; redirect_pending ← 0.
- stall=0, req=0, redirect_pending=0: pc ← pc + INC, modulo 2^WIDTH (wraps to 0).

**Misalignment flag.** misaligned ← 1 only on an edge where a redirect target is applied to pc and its original bits [1:0] ≠ 0. It is 0 on every other edge, including stall edges and sequential edges.

**Arithmetic.** All additions are unsigned, truncated to WIDTH bits, with no carry out.

## Timing

- Latency: a request sampled at edge N appears on pc after edge N (one cycle).
- A held redirect appears on pc one cycle after stall deasserts.
- pc_seq tracks pc combinationally, with zero latency.
- redirect_pending rises the cycle after the first stalled request. It falls on the edge that applies the held target, or the live redirect that displaces it.
- misaligned is high for exactly one cycle, aligned with the pc update that loaded the bad target.
- Reset asserted mid-stall with a pending redirect clears the redirect; pc = RESET_VECTOR on the following cycle.
- After reset deasserts, the first increment occurs on the next non-stalled edge.
- Outputs after reset: pc=RESET_VECTOR, pc_seq=RESET_VECTOR+INC, redirect_pending=0, misaligned=0.

## Test plan

1. **Sequential run and wrap.** Stimulus: reset for 1 cycle, then 4 idle cycles. Required: pc = 0, 4, 8, 12, 16; pc_seq = pc+4. Then with RESET_VECTOR=32'hFFFF_FFF8: pc = FFFF_FFF8, FFFF_FFFC, 0000_0000.
2. **Priority.** Stimulus: at pc=0x100, assert jr, jump and branch_taken together, with jr_addr=0x400, jump_index=0x40, bta=0x200. Required: pc=0x400 next. Repeat without jr: required pc=0x100 (upper bits {0}, index 0x40<<2). Repeat with branch only: required pc=0x200.
3. **Stalled redirect.** Stimulus: stall=1 for 3 cycles; branch_taken=1 with bta=0x300 in cycle 1 only. Required: pc frozen, redirect_pending=1 from cycle 2; when stall drops, pc=0x300 and redirect_pending=0.
4. **Latest-wins and live override.** Stimulus: during a stall, branch to 0x300, then jr to 0x500. Required: held target 0x500. Then release the stall with a live jump whose target is 0x800. Required: pc=0x800 and pending cleared.
5. **Misaligned.** Stimulus: jr with jr_addr=0x1006. Required: pc=0x1004, misaligned=1 for one cycle, then 0 on the next sequential step (pc=0x1008).
6. **Reset mid-stall.** Stimulus: a pending redirect to 0x300, then reset=1 while stall=1. Required: pc=RESET_VECTOR, redirect_pending=0, misaligned=0. After release with no request, pc advances by INC.
